// File: rtl/ex_stage_mem_reg.sv
// ---------------------------------------------------------------------------
// ex_stage_mem_reg
// Execute stage of the 5-stage RV32 pipeline. It computes the ALU result,
// branch/jump resolution and store data from the ID/EX register outputs, and
// latches them into the EX/MEM pipeline register on the falling clock edge.
//
// Optional feature macro: EX_MUL_EN
//   defined   -> iterative shift-and-add multiplier (ALU code 4'b1111) with an
//                IDLE/BUSY/DONE FSM that raises stall_EX while it runs
//   undefined -> no multiplier, stall_EX tied low, code 4'b1111 yields 0
//
// Ports
//   clk_EXMEM            pipeline clock, state changes on the falling edge
//   rst_EXMEM            asynchronous active-low reset
//   en_EXMEM             EX/MEM load enable (low = hold)
//   PC/Rs1/Rs2/Imm_in_EX operands from ID/EX
//   Rd_addr_in_EX        destination register
//   ALUSrc_B_in_EX       operand B select (1 = Imm, 0 = Rs2)
//   ALU_control_in_EX    ALU operation select
//   Branch/BranchN_in_EX BEQ-type / BNE-type branch
//   Jump_in_EX           00 none, 01 JAL, 10 JALR, 11 none
//   MemRW/RegWrite/MemtoReg_in_EX  control passed down the pipe
//   stall_EX             freeze PC, IF/ID and ID/EX while high
//   *_out_EXMEM          EX/MEM register outputs
// ---------------------------------------------------------------------------
module ex_stage_mem_reg (
  input  logic        clk_EXMEM,
  input  logic        rst_EXMEM,
  input  logic        en_EXMEM,
  input  logic [31:0] PC_in_EX,
  input  logic [31:0] Rs1_in_EX,
  input  logic [31:0] Rs2_in_EX,
  input  logic [31:0] Imm_in_EX,
  input  logic [4:0]  Rd_addr_in_EX,
  input  logic        ALUSrc_B_in_EX,
  input  logic [3:0]  ALU_control_in_EX,
  input  logic        Branch_in_EX,
  input  logic        BranchN_in_EX,
  input  logic [1:0]  Jump_in_EX,
  input  logic        MemRW_in_EX,
  input  logic        RegWrite_in_EX,
  input  logic [1:0]  MemtoReg_in_EX,
  output logic        stall_EX,
  output logic [31:0] PC_out_EXMEM,
  output logic [31:0] PC4_out_EXMEM,
  output logic [31:0] ALU_out_EXMEM,
  output logic [31:0] Rs2_out_EXMEM,
  output logic [31:0] Target_out_EXMEM,
  output logic [4:0]  Rd_addr_out_EXMEM,
  output logic        Taken_out_EXMEM,
  output logic        MemRW_out_EXMEM,
  output logic        RegWrite_out_EXMEM,
  output logic [1:0]  MemtoReg_out_EXMEM
);

  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        taken;
  logic [31:0] target;
  logic [31:0] jalr_sum;

  assign op_a = Rs1_in_EX;
  assign op_b = ALUSrc_B_in_EX ? Imm_in_EX : Rs2_in_EX;

`ifdef EX_MUL_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

  mul_state_t  state, state_next;
  logic [31:0] mcand, mcand_next;
  logic [31:0] mplier, mplier_next;
  logic [31:0] prod, prod_next;
  logic [5:0]  count, count_next;
  logic        is_mul;

  assign is_mul = (ALU_control_in_EX == 4'b1111);

  always_ff @(negedge clk_EXMEM or negedge rst_EXMEM) begin
    if (!rst_EXMEM) begin
      state  <= IDLE;
      mcand  <= 32'd0;
      mplier <= 32'd0;
      prod   <= 32'd0;
      count  <= 6'd0;
    end else begin
      state  <= state_next;
      mcand  <= mcand_next;
      mplier <= mplier_next;
      prod   <= prod_next;
      count  <= count_next;
    end
  end

  // 32 add/shift iterations (count 0..31), then one more BUSY edge with
  // count == 32 moves to DONE, so DONE is reached 33 edges after the load.
  always_comb begin
    state_next  = state;
    mcand_next  = mcand;
    mplier_next = mplier;
    prod_next   = prod;
    count_next  = count;
    case (state)
      IDLE: begin
        if (is_mul) begin
          mcand_next  = op_a;
          mplier_next = op_b;
          prod_next   = 32'd0;
          count_next  = 6'd0;
          state_next  = BUSY;
        end
      end
      BUSY: begin
        if (count == 6'd32) begin
          state_next = DONE;
        end else begin
          if (mplier[0]) prod_next = prod + mcand;
          mcand_next  = mcand << 1;
          mplier_next = mplier >> 1;
          count_next  = count + 6'd1;
        end
      end
      DONE: begin
        // The product stays on the ALU output until EX/MEM actually takes it.
        if (en_EXMEM) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign stall_EX = is_mul && (state != DONE);
`else
  assign stall_EX = 1'b0;
`endif

  always_comb begin
    alu_result = 32'd0;
    case (ALU_control_in_EX)
      4'b0000: alu_result = op_a + op_b;
      4'b0001: alu_result = op_a - op_b;
      4'b0010: alu_result = op_a & op_b;
      4'b0011: alu_result = op_a | op_b;
      4'b0100: alu_result = op_a ^ op_b;
      4'b0101: alu_result = op_a << op_b[4:0];
      4'b0110: alu_result = op_a >> op_b[4:0];
      4'b0111: alu_result = $signed(op_a) >>> op_b[4:0];
      4'b1000: alu_result = {31'd0, ($signed(op_a) < $signed(op_b))};
      4'b1001: alu_result = {31'd0, (op_a < op_b)};
`ifdef EX_MUL_EN
      4'b1111: alu_result = prod;
`endif
      default: alu_result = 32'd0;
    endcase
  end

  assign alu_zero = (alu_result == 32'd0);
  assign taken    = (Branch_in_EX & alu_zero) | (BranchN_in_EX & ~alu_zero) |
                    (Jump_in_EX == 2'b01) | (Jump_in_EX == 2'b10);
  assign jalr_sum = Rs1_in_EX + Imm_in_EX;
  assign target   = (Jump_in_EX == 2'b10) ? {jalr_sum[31:1], 1'b0}
                                          : (PC_in_EX + Imm_in_EX);

  // EX/MEM register; a stalled multiply inserts an all-zero bubble.
  always_ff @(negedge clk_EXMEM or negedge rst_EXMEM) begin
    if (!rst_EXMEM) begin
      PC_out_EXMEM       <= 32'd0;
      PC4_out_EXMEM      <= 32'd0;
      ALU_out_EXMEM      <= 32'd0;
      Rs2_out_EXMEM      <= 32'd0;
      Target_out_EXMEM   <= 32'd0;
      Rd_addr_out_EXMEM  <= 5'd0;
      Taken_out_EXMEM    <= 1'b0;
      MemRW_out_EXMEM    <= 1'b0;
      RegWrite_out_EXMEM <= 1'b0;
      MemtoReg_out_EXMEM <= 2'b00;
    end else if (en_EXMEM) begin
      if (stall_EX) begin
        PC_out_EXMEM       <= 32'd0;
        PC4_out_EXMEM      <= 32'd0;
        ALU_out_EXMEM      <= 32'd0;
        Rs2_out_EXMEM      <= 32'd0;
        Target_out_EXMEM   <= 32'd0;
        Rd_addr_out_EXMEM  <= 5'd0;
        Taken_out_EXMEM    <= 1'b0;
        MemRW_out_EXMEM    <= 1'b0;
        RegWrite_out_EXMEM <= 1'b0;
        MemtoReg_out_EXMEM <= 2'b00;
      end else begin
        PC_out_EXMEM       <= PC_in_EX;
        PC4_out_EXMEM      <= PC_in_EX + 32'd4;
        ALU_out_EXMEM      <= alu_result;
        Rs2_out_EXMEM      <= Rs2_in_EX;
        Target_out_EXMEM   <= target;
        Rd_addr_out_EXMEM  <= Rd_addr_in_EX;
        Taken_out_EXMEM    <= taken;
        MemRW_out_EXMEM    <= MemRW_in_EX;
        RegWrite_out_EXMEM <= RegWrite_in_EX;
        MemtoReg_out_EXMEM <= MemtoReg_in_EX;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage_mem_reg.sv
// ---------------------------------------------------------------------------
// tb_ex_stage_mem_reg
// Self-checking bench for ex_stage_mem_reg: reset behaviour, a table of
// directed vectors, randomized vectors against a reference model, and (when
// EX_MUL_EN is defined) multi-cycle multiply sequences.
// ---------------------------------------------------------------------------
module tb_ex_stage_mem_reg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        alusrc;
    logic [3:0]  aluc;
    logic        br;
    logic        brn;
    logic [1:0]  jump;
    logic        memrw;
    logic        regw;
    logic [1:0]  m2r;
  } in_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [31:0] tgt;
    logic [4:0]  rd;
    logic        taken;
    logic        memrw;
    logic        regw;
    logic [1:0]  m2r;
  } out_t;

  typedef struct packed {
    in_t         in;
    logic [31:0] e_alu;
    logic        e_taken;
    logic [31:0] e_tgt;
  } vec_t;

  logic        clk_EXMEM;
  logic        rst_EXMEM;
  logic        en_EXMEM;
  logic [31:0] PC_in_EX, Rs1_in_EX, Rs2_in_EX, Imm_in_EX;
  logic [4:0]  Rd_addr_in_EX;
  logic        ALUSrc_B_in_EX;
  logic [3:0]  ALU_control_in_EX;
  logic        Branch_in_EX, BranchN_in_EX;
  logic [1:0]  Jump_in_EX;
  logic        MemRW_in_EX, RegWrite_in_EX;
  logic [1:0]  MemtoReg_in_EX;
  logic        stall_EX;
  logic [31:0] PC_out_EXMEM, PC4_out_EXMEM, ALU_out_EXMEM, Rs2_out_EXMEM, Target_out_EXMEM;
  logic [4:0]  Rd_addr_out_EXMEM;
  logic        Taken_out_EXMEM, MemRW_out_EXMEM, RegWrite_out_EXMEM;
  logic [1:0]  MemtoReg_out_EXMEM;

  int checks = 0;
  int errors = 0;

  ex_stage_mem_reg dut (
    .clk_EXMEM(clk_EXMEM), .rst_EXMEM(rst_EXMEM), .en_EXMEM(en_EXMEM),
    .PC_in_EX(PC_in_EX), .Rs1_in_EX(Rs1_in_EX), .Rs2_in_EX(Rs2_in_EX),
    .Imm_in_EX(Imm_in_EX), .Rd_addr_in_EX(Rd_addr_in_EX),
    .ALUSrc_B_in_EX(ALUSrc_B_in_EX), .ALU_control_in_EX(ALU_control_in_EX),
    .Branch_in_EX(Branch_in_EX), .BranchN_in_EX(BranchN_in_EX),
    .Jump_in_EX(Jump_in_EX), .MemRW_in_EX(MemRW_in_EX),
    .RegWrite_in_EX(RegWrite_in_EX), .MemtoReg_in_EX(MemtoReg_in_EX),
    .stall_EX(stall_EX), .PC_out_EXMEM(PC_out_EXMEM), .PC4_out_EXMEM(PC4_out_EXMEM),
    .ALU_out_EXMEM(ALU_out_EXMEM), .Rs2_out_EXMEM(Rs2_out_EXMEM),
    .Target_out_EXMEM(Target_out_EXMEM), .Rd_addr_out_EXMEM(Rd_addr_out_EXMEM),
    .Taken_out_EXMEM(Taken_out_EXMEM), .MemRW_out_EXMEM(MemRW_out_EXMEM),
    .RegWrite_out_EXMEM(RegWrite_out_EXMEM), .MemtoReg_out_EXMEM(MemtoReg_out_EXMEM)
  );

  initial clk_EXMEM = 1'b1;
  always #5 clk_EXMEM = ~clk_EXMEM;

  // Reference model: straight from the instruction semantics.
  function automatic out_t model(input in_t v);
    out_t        o;
    logic [31:0] b;
    logic [31:0] r;
    b = v.alusrc ? v.imm : v.rs2;
    case (v.aluc)
      4'd0: r = v.rs1 + b;
      4'd1: r = v.rs1 - b;
      4'd2: r = v.rs1 & b;
      4'd3: r = v.rs1 | b;
      4'd4: r = v.rs1 ^ b;
      4'd5: r = v.rs1 << (b % 32);
      4'd6: r = v.rs1 >> (b % 32);
      4'd7: r = 32'($signed(v.rs1) >>> (b % 32));
      4'd8: r = (int'(v.rs1) < int'(b)) ? 32'd1 : 32'd0;
      4'd9: r = (v.rs1 < b) ? 32'd1 : 32'd0;
`ifdef EX_MUL_EN
      4'd15: r = v.rs1 * b;
`endif
      default: r = 32'd0;
    endcase
    o.pc    = v.pc;
    o.pc4   = v.pc + 32'd4;
    o.alu   = r;
    o.rs2   = v.rs2;
    o.tgt   = (v.jump == 2'd2) ? ((v.rs1 + v.imm) & 32'hFFFF_FFFE) : (v.pc + v.imm);
    o.rd    = v.rd;
    o.taken = (v.br && r == 0) || (v.brn && r != 0) || v.jump == 2'd1 || v.jump == 2'd2;
    o.memrw = v.memrw;
    o.regw  = v.regw;
    o.m2r   = v.m2r;
    return o;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input in_t v, input logic en);
    PC_in_EX          = v.pc;
    Rs1_in_EX         = v.rs1;
    Rs2_in_EX         = v.rs2;
    Imm_in_EX         = v.imm;
    Rd_addr_in_EX     = v.rd;
    ALUSrc_B_in_EX    = v.alusrc;
    ALU_control_in_EX = v.aluc;
    Branch_in_EX      = v.br;
    BranchN_in_EX     = v.brn;
    Jump_in_EX        = v.jump;
    MemRW_in_EX       = v.memrw;
    RegWrite_in_EX    = v.regw;
    MemtoReg_in_EX    = v.m2r;
    en_EXMEM          = en;
  endtask

  task automatic checkOutput(input string tag, input out_t e);
    cmp({tag, ".pc"},    PC_out_EXMEM, e.pc);
    cmp({tag, ".pc4"},   PC4_out_EXMEM, e.pc4);
    cmp({tag, ".alu"},   ALU_out_EXMEM, e.alu);
    cmp({tag, ".rs2"},   Rs2_out_EXMEM, e.rs2);
    cmp({tag, ".tgt"},   Target_out_EXMEM, e.tgt);
    cmp({tag, ".rd"},    {27'd0, Rd_addr_out_EXMEM}, {27'd0, e.rd});
    cmp({tag, ".taken"}, {31'd0, Taken_out_EXMEM}, {31'd0, e.taken});
    cmp({tag, ".memrw"}, {31'd0, MemRW_out_EXMEM}, {31'd0, e.memrw});
    cmp({tag, ".regw"},  {31'd0, RegWrite_out_EXMEM}, {31'd0, e.regw});
    cmp({tag, ".m2r"},   {30'd0, MemtoReg_out_EXMEM}, {30'd0, e.m2r});
  endtask

  task automatic tick();
    @(negedge clk_EXMEM);
    #1;
  endtask

  function automatic in_t mk(input logic [31:0] pc, rs1, rs2, imm, input logic alusrc,
                             input logic [3:0] aluc, input logic br, brn, input logic [1:0] jump);
    in_t v;
    v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.rd = 5'd3;
    v.alusrc = alusrc; v.aluc = aluc; v.br = br; v.brn = brn; v.jump = jump;
    v.memrw = 1'b0; v.regw = 1'b1; v.m2r = 2'b01;
    return v;
  endfunction

`ifdef EX_MUL_EN
  // Clocks edges until stall_EX drops; every stalled enabled edge must be a bubble.
  task automatic waitStallLow(input string tag, input logic expect_bubble, output int edges);
    edges = 0;
    while (stall_EX === 1'b1 && edges < 200) begin
      tick();
      edges++;
      if (stall_EX === 1'b1 && expect_bubble)
        cmp({tag, ".bubble_regw"}, {31'd0, RegWrite_out_EXMEM}, 32'd0);
    end
    if (edges >= 200) begin
      checks++; errors++;
      $display("[TB] FAIL %s.timeout: got stall stuck, expected release", tag);
    end
  endtask
`endif

  vec_t  vecs[11];
  out_t  zero_out;
  out_t  exp_reg;
  in_t   v;
  int    n;
  logic  en_r;
  logic [3:0] codes[11];

  initial begin
    zero_out = '0;
    //                  pc            rs1           rs2           imm           src aluc  br brn jump
    vecs[0]  = '{mk(32'h40,       32'hFFFFFFFF, 32'h0,        32'h1,        1, 4'd0, 0, 0, 2'd0), 32'h0,        1'b0, 32'h41};
    vecs[1]  = '{mk(32'h0,        32'h80000000, 32'h4,        32'h0,        0, 4'd7, 0, 0, 2'd0), 32'hF8000000, 1'b0, 32'h0};
    vecs[2]  = '{mk(32'h100,      32'h5,        32'h5,        32'h20,       0, 4'd1, 1, 0, 2'd0), 32'h0,        1'b1, 32'h120};
    vecs[3]  = '{mk(32'h100,      32'h5,        32'h5,        32'h20,       0, 4'd1, 0, 1, 2'd0), 32'h0,        1'b0, 32'h120};
    vecs[4]  = '{mk(32'h200,      32'h1003,     32'h0,        32'h4,        1, 4'd0, 0, 0, 2'd2), 32'h1007,     1'b1, 32'h1006};
    vecs[5]  = '{mk(32'h300,      32'h0,        32'h0,        32'h10,       1, 4'd0, 0, 0, 2'd1), 32'h10,       1'b1, 32'h310};
    vecs[6]  = '{mk(32'h0,        32'hFFFFFFFF, 32'h1,        32'h0,        0, 4'd8, 0, 0, 2'd0), 32'h1,        1'b0, 32'h0};
    vecs[7]  = '{mk(32'h0,        32'hFFFFFFFF, 32'h1,        32'h0,        0, 4'd9, 0, 0, 2'd0), 32'h0,        1'b0, 32'h0};
    vecs[8]  = '{mk(32'h10,       32'h5,        32'h0,        32'h8,        0, 4'hC, 0, 0, 2'd3), 32'h0,        1'b0, 32'h18};
    vecs[9]  = '{mk(32'h100,      32'h5,        32'h6,        32'hFFFFFFF0, 0, 4'd1, 0, 1, 2'd0), 32'hFFFFFFFF, 1'b1, 32'hF0};
    vecs[10] = '{mk(32'h0,        32'h1,        32'h0,        32'h3F,       1, 4'd5, 0, 0, 2'd0), 32'h80000000, 1'b0, 32'h3F};
    codes = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'hC};

    // Load a value, then assert reset mid-cycle: outputs must clear at once.
    rst_EXMEM = 1'b1;
    applyStimulus(mk(32'h8, 32'h1, 32'h2, 32'h0, 0, 4'd0, 0, 0, 2'd0), 1'b1);
    tick();
    cmp("preload.alu", ALU_out_EXMEM, 32'h3);
    #3;
    rst_EXMEM = 1'b0;
    #1;
    checkOutput("reset_async", zero_out);
    cmp("reset.stall", {31'd0, stall_EX}, 32'd0);
    tick();
    checkOutput("reset_held", zero_out);
    rst_EXMEM = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].in, 1'b1);
      tick();
      cmp($sformatf("vec%0d.alu", i), ALU_out_EXMEM, vecs[i].e_alu);
      cmp($sformatf("vec%0d.taken", i), {31'd0, Taken_out_EXMEM}, {31'd0, vecs[i].e_taken});
      cmp($sformatf("vec%0d.tgt", i), Target_out_EXMEM, vecs[i].e_tgt);
      cmp($sformatf("vec%0d.pc4", i), PC4_out_EXMEM, vecs[i].in.pc + 32'd4);
      cmp($sformatf("vec%0d.stall", i), {31'd0, stall_EX}, 32'd0);
    end

    // Randomized vectors with random enable; expected state kept by the bench.
    exp_reg = model(vecs[10].in);
    for (int k = 0; k < 60; k++) begin
      v.pc = $urandom; v.rs1 = $urandom; v.imm = $urandom;
      v.rs2 = ($urandom_range(0, 3) == 0) ? v.rs1 : $urandom;
      v.rd = 5'($urandom); v.alusrc = 1'($urandom);
      v.aluc = codes[$urandom_range(0, 10)];
      v.br = 1'($urandom); v.brn = 1'($urandom); v.jump = 2'($urandom);
      v.memrw = 1'($urandom); v.regw = 1'($urandom); v.m2r = 2'($urandom);
      en_r = ($urandom_range(0, 3) != 0);
      applyStimulus(v, en_r);
      tick();
      if (en_r) exp_reg = model(v);
      checkOutput($sformatf("rand%0d", k), exp_reg);
    end

`ifndef EX_MUL_EN
    // Without the multiplier, code 1111 is an ordinary zero-result op.
    applyStimulus(mk(32'h50, 32'h3, 32'h4, 32'h0, 0, 4'hF, 0, 0, 2'd0), 1'b1);
    #1;
    cmp("nomul.stall", {31'd0, stall_EX}, 32'd0);
    tick();
    cmp("nomul.alu", ALU_out_EXMEM, 32'h0);
    cmp("nomul.regw", {31'd0, RegWrite_out_EXMEM}, 32'd1);
`else
    // MUL 0x12345678 * 0x10 with enable high.
    v = mk(32'h60, 32'h12345678, 32'h0, 32'h10, 1, 4'hF, 0, 0, 2'd0);
    v.rd = 5'd7;
    applyStimulus(v, 1'b1);
    #1;
    cmp("mul1.stall_pre", {31'd0, stall_EX}, 32'd1);
    waitStallLow("mul1", 1'b1, n);
    cmp("mul1.edges", n, 34);
    tick();
    cmp("mul1.alu", ALU_out_EXMEM, 32'h23456780);
    cmp("mul1.regw", {31'd0, RegWrite_out_EXMEM}, 32'd1);
    cmp("mul1.rd", {27'd0, Rd_addr_out_EXMEM}, 32'd7);
    applyStimulus(mk(32'h64, 32'd20, 32'd22, 32'h0, 0, 4'd0, 0, 0, 2'd0), 1'b1);
    #1;
    cmp("mul1.stall_after", {31'd0, stall_EX}, 32'd0);
    tick();
    cmp("add42.alu", ALU_out_EXMEM, 32'd42);

    // MUL with enable held low through the run and 5 edges past DONE.
    applyStimulus(mk(32'h68, 32'd7, 32'd6, 32'h0, 0, 4'hF, 0, 0, 2'd0), 1'b0);
    waitStallLow("mul2", 1'b0, n);
    cmp("mul2.edges", n, 34);
    cmp("mul2.held_busy", ALU_out_EXMEM, 32'd42);
    for (int k = 0; k < 5; k++) begin
      tick();
      cmp($sformatf("mul2.hold%0d.alu", k), ALU_out_EXMEM, 32'd42);
      cmp($sformatf("mul2.hold%0d.stall", k), {31'd0, stall_EX}, 32'd0);
    end
    en_EXMEM = 1'b1;
    tick();
    cmp("mul2.alu", ALU_out_EXMEM, 32'd42 + 32'd0);
    cmp("mul2.pc", PC_out_EXMEM, 32'h68);
    applyStimulus(mk(32'h6C, 32'd1, 32'd1, 32'h0, 0, 4'd0, 0, 0, 2'd0), 1'b1);
    tick();
    cmp("add2.alu", ALU_out_EXMEM, 32'd2);

    // Reset pulsed at iteration 10 aborts the multiply; it restarts afterwards.
    applyStimulus(mk(32'h70, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 0, 4'hF, 0, 0, 2'd0), 1'b1);
    for (int k = 0; k < 10; k++) tick();
    #3;
    rst_EXMEM = 1'b0;
    #1;
    cmp("mul3.rst_alu", ALU_out_EXMEM, 32'd0);
    cmp("mul3.rst_stall", {31'd0, stall_EX}, 32'd1);
    tick();
    rst_EXMEM = 1'b1;
    #1;
    waitStallLow("mul3", 1'b1, n);
    cmp("mul3.edges", n, 34);
    tick();
    cmp("mul3.alu", ALU_out_EXMEM, 32'd1);
    applyStimulus(mk(32'h74, 32'd0, 32'd0, 32'h0, 0, 4'd0, 0, 0, 2'd0), 1'b1);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
